// File: rtl/lagarto_plic_gateway_array.sv
// lagarto_plic_gateway_array: bank of clocked PLIC gateways forwarding one request per source until completed
// Ports: clk_i/rst_ni (sync active-low), interrupt_signal_i/interrupt_edge_mode_i per-source line and mode,
// claim_valid_i/claim_id_i and complete_valid_i/complete_id_i from the PLIC (ID = source+1, 0 = none),
// interrupt_request_o per-source pending request, interrupt_in_service_o per-source claimed-not-completed.
// Optional LAGARTO_PLIC_GW_SYNC_EN: 2-flop synchroniser on every interrupt line (3-cycle trigger latency).
module lagarto_plic_gateway_array #(
  parameter int NUM_SOURCES = 32,
  parameter int MAX_PENDING = 4,
  parameter int ID_W = $clog2(NUM_SOURCES + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NUM_SOURCES-1:0] interrupt_signal_i,
  input  logic [NUM_SOURCES-1:0] interrupt_edge_mode_i,
  input  logic                   claim_valid_i,
  input  logic [ID_W-1:0]        claim_id_i,
  input  logic                   complete_valid_i,
  input  logic [ID_W-1:0]        complete_id_i,
  output logic [NUM_SOURCES-1:0] interrupt_request_o,
  output logic [NUM_SOURCES-1:0] interrupt_in_service_o
);
  localparam int CW = $clog2(MAX_PENDING + 1);
  typedef enum logic [1:0] {IDLE, REQUEST, CLAIMED} state_e;
  logic [NUM_SOURCES-1:0] sig;
  logic [NUM_SOURCES-1:0] prev_q;
  logic [NUM_SOURCES-1:0] mode_q;
`ifdef LAGARTO_PLIC_GW_SYNC_EN
  logic [NUM_SOURCES-1:0] sync_q1, sync_q2;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= interrupt_signal_i;
      sync_q2 <= sync_q1;
    end
  end
  assign sig = sync_q2;
`else
  assign sig = interrupt_signal_i;
`endif
  always_ff @(posedge clk_i) prev_q <= rst_ni ? sig : '0;
  // mode history only detects toggles, so it tracks the input even through reset
  always_ff @(posedge clk_i) mode_q <= interrupt_edge_mode_i;
  for (genvar g = 0; g < NUM_SOURCES; g++) begin : gw
    localparam logic [ID_W-1:0] src_id = ID_W'(g + 1);
    state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic edge_det, claim_hit, complete_hit, trig;
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end
    always_comb begin
      edge_det     = sig[g] & ~prev_q[g];
      claim_hit    = claim_valid_i && claim_id_i == src_id;
      complete_hit = complete_valid_i && complete_id_i == src_id;
      trig         = interrupt_edge_mode_i[g] ? (edge_det || cnt_q != '0) : sig[g];
      state_d      = state_q;
      cnt_d        = cnt_q;
      case (state_q)
        IDLE:    state_d = trig ? REQUEST : IDLE;
        REQUEST: state_d = claim_hit ? CLAIMED : REQUEST;
        CLAIMED: state_d = complete_hit ? IDLE : CLAIMED;
        default: state_d = IDLE;
      endcase
      // an edge in IDLE consumes the request slot itself, so the backlog only drains on edge-free cycles
      if (interrupt_edge_mode_i[g])
        cnt_d = state_q == IDLE ? ((cnt_q != '0 && !edge_det) ? cnt_q - CW'(1) : cnt_q)
                                : ((edge_det && cnt_q != CW'(MAX_PENDING)) ? cnt_q + CW'(1) : cnt_q);
      if (interrupt_edge_mode_i[g] != mode_q[g]) cnt_d = '0;
    end
    assign interrupt_request_o[g]    = state_q == REQUEST;
    assign interrupt_in_service_o[g] = state_q == CLAIMED;
  end
endmodule

// File: tb/tb_lagarto_plic_gateway_array.sv
// tb_lagarto_plic_gateway_array: directed plus randomized check of the gateway bank against a behavioural model
module tb_lagarto_plic_gateway_array;
  localparam int N = 4;
  localparam int MP = 4;
  localparam int IW = 3;
`ifdef LAGARTO_PLIC_GW_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif
  logic clk = 0;
  logic rst_n = 0;
  logic [N-1:0] sig = '0;
  logic [N-1:0] mode = '0;
  logic cv = 0;
  logic [IW-1:0] cid = '0;
  logic pv = 0;
  logic [IW-1:0] pid = '0;
  logic [N-1:0] req, isv;
  int checks = 0;
  int failures = 0;
  bit cmp_en = 0;
  always #5 clk = ~clk;
  lagarto_plic_gateway_array #(.NUM_SOURCES(N), .MAX_PENDING(MP)) dut (
    .clk_i(clk), .rst_ni(rst_n), .interrupt_signal_i(sig), .interrupt_edge_mode_i(mode),
    .claim_valid_i(cv), .claim_id_i(cid), .complete_valid_i(pv), .complete_id_i(pid),
    .interrupt_request_o(req), .interrupt_in_service_o(isv));
  bit m_req[N], m_isv[N], m_prev[N], m_mp[N], m_s1[N], m_s2[N];
  int m_cnt[N];
  logic [N-1:0] m_reqv = '0, m_isvv = '0;
  always @(posedge clk) begin
    for (int s = 0; s < N; s++) begin
      bit smp, e, em, cl, co;
      smp = (LAT == 3) ? m_s2[s] : sig[s];
      e   = smp && !m_prev[s];
      em  = mode[s];
      cl  = cv && int'(cid) == s + 1;
      co  = pv && int'(pid) == s + 1;
      if (!rst_n) begin
        m_req[s] = 0; m_isv[s] = 0; m_cnt[s] = 0; m_prev[s] = 0; m_s1[s] = 0; m_s2[s] = 0;
      end else begin
        if (!m_req[s] && !m_isv[s]) begin
          bit fire;
          fire = em ? (e || m_cnt[s] > 0) : smp;
          if (em && m_cnt[s] > 0 && !e) m_cnt[s]--;
          m_req[s] = fire;
        end else begin
          if (em && e && m_cnt[s] < MP) m_cnt[s]++;
          if (m_req[s] && cl) begin m_req[s] = 0; m_isv[s] = 1; end
          else if (m_isv[s] && co) m_isv[s] = 0;
        end
        if (em != m_mp[s]) m_cnt[s] = 0;
        m_prev[s] = smp;
        m_s2[s] = m_s1[s];
        m_s1[s] = sig[s];
      end
      m_mp[s] = em;
      m_reqv[s] = m_req[s];
      m_isvv[s] = m_isv[s];
    end
  end
  task automatic check(string name, logic [N-1:0] act, logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b t=%0t", name, act, exp, $time);
    end
  endtask
  task automatic check_int(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) if (cmp_en) begin
    check("model_req", req, m_reqv);
    check("model_isv", isv, m_isvv);
  end
  task automatic step(); @(posedge clk); #1; endtask
  task automatic steps(int n); repeat (n) step(); endtask
  task automatic claim(int id); cv = 1; cid = IW'(id); step(); cv = 0; endtask
  task automatic complete(int id); pv = 1; pid = IW'(id); step(); pv = 0; endtask
  task automatic pulse(int s); sig[s] = 1; step(); sig[s] = 0; step(); endtask
  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    int lat, rounds;
    bit found;
    steps(2);
    rst_n = 1;
    cmp_en = 1;
    check("reset_req", req, 4'b0000);
    check("reset_isv", isv, 4'b0000);
    sig[2] = 1;
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (req[2]) begin lat = i; break; end
    end
    check_int("level_latency", lat, LAT);
    check("lvl_req", req, 4'b0100);
    check("pin_model_lvl", m_reqv, 4'b0100);
    claim(3);
    check("claim_req", req, 4'b0000);
    check("claim_isv", isv, 4'b0100);
    complete(3);
    check("cmp_idle_req", req, 4'b0000);
    check("cmp_idle_isv", isv, 4'b0000);
    step();
    check("relevel_req", req, 4'b0100);
    sig[2] = 0;
    claim(3);
    complete(3);
    steps(4);
    check("lvl_drained", req | isv, 4'b0000);
    mode[0] = 1;
    step();
    pulse(0);
    steps(LAT);
    check("edge_req", req, 4'b0001);
    claim(1);
    check("edge_isv", isv, 4'b0001);
    repeat (6) pulse(0);
    steps(3);
    complete(1);
    rounds = 0;
    for (int r = 0; r < 6; r++) begin
      found = 0;
      for (int i = 0; i < 6; i++) begin
        if (req[0]) begin found = 1; break; end
        step();
      end
      if (!found) break;
      rounds++;
      claim(1);
      complete(1);
    end
    check_int("edge_rounds", rounds, MP);
    steps(5);
    check("edge_drained", req, 4'b0000);
    claim(0);
    check("bad_id0", req | isv, 4'b0000);
    claim(5);
    check("bad_id5", req | isv, 4'b0000);
    claim(1);
    check("claim_idle", req | isv, 4'b0000);
    sig[1] = 1;
    steps(LAT);
    sig[1] = 0;
    check("src1_req", req, 4'b0010);
    complete(2);
    check("cmp_in_req_req", req, 4'b0010);
    check("cmp_in_req_isv", isv, 4'b0000);
    pulse(0);
    steps(LAT);
    check("both_req", req, 4'b0011);
    check("pin_model_both", m_reqv, 4'b0011);
    cv = 1; cid = 1; pv = 1; pid = 1;
    step();
    cv = 0; pv = 0;
    check("same_id_isv", isv, 4'b0001);
    check("same_id_req", req, 4'b0010);
    claim(2);
    check("claim2_isv", isv, 4'b0011);
    complete(1);
    check("cmp1_isv", isv, 4'b0010);
    pulse(0);
    steps(LAT);
    check("src0_rereq", req, 4'b0001);
    cv = 1; cid = 1; pv = 1; pid = 2;
    step();
    cv = 0; pv = 0;
    check("dual_isv", isv, 4'b0001);
    check("dual_req", req, 4'b0000);
    complete(1);
    check("dual_done", isv, 4'b0000);
    pulse(0);
    steps(LAT);
    claim(1);
    repeat (3) pulse(0);
    steps(3);
    check("pre_reset_isv", isv, 4'b0001);
    rst_n = 0;
    step();
    rst_n = 1;
    check("midreset_req", req, 4'b0000);
    check("midreset_isv", isv, 4'b0000);
    steps(10);
    check("post_reset_quiet", req | isv, 4'b0000);
    mode = N'($urandom);
    for (int c = 0; c < 3000; c++) begin
      for (int s = 0; s < N; s++) sig[s] = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 499) == 0) mode[$urandom_range(0, N - 1)] ^= 1'b1;
      cv = ($urandom_range(0, 2) == 0);
      cid = IW'($urandom_range(0, 5));
      pv = ($urandom_range(0, 2) == 0);
      pid = IW'($urandom_range(0, 5));
      rst_n = ($urandom_range(0, 399) != 0);
      step();
    end
    rst_n = 1; cv = 0; pv = 0; sig = '0;
    steps(4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
